// File: rtl/ws2812b_frame_sequencer_if.sv
// Pixel-memory and shift-buffer bus of the WS2812B frame sequencer.
// master = sequencer side, slave = frame RAM / shift buffer / requester side.
interface ws2812b_frame_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              busy;
  logic              done;
  logic              pix_rd;
  logic [ADDR_W-1:0] pix_addr;
  logic [23:0]       pix_data;
  logic [23:0]       buf_data;
  logic              buf_load;
  logic              buf_shift;
  logic              buf_valid;

  modport master (
    input  start, pix_data,
    output busy, done, pix_rd, pix_addr, buf_data, buf_load, buf_shift, buf_valid
  );

  modport slave (
    output start, pix_data,
    input  busy, done, pix_rd, pix_addr, buf_data, buf_load, buf_shift, buf_valid
  );
endinterface

// File: rtl/ws2812b_frame_sequencer.sv
// Streams NUM_LEDS GRB words from pixel RAM into the WS2812B shift buffer, then idles for the latch gap.
// Define WS2812B_AUTO_REFRESH_EN to restart the frame automatically after every latch gap.
module ws2812b_frame_sequencer #(
  parameter int NUM_LEDS     = 60,
  parameter int ADDR_W       = 8,
  parameter int LATCH_CYCLES = 64
) (
  input  logic scl,
  input  logic reset,
  ws2812b_frame_sequencer_if.master bus
);

  localparam int                LAT_W        = $clog2(LATCH_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_PIX     = ADDR_W'(NUM_LEDS - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE      = ADDR_W'(1);
  localparam logic [LAT_W-1:0]  LAT_LAST     = LAT_W'(LATCH_CYCLES - 1);
  localparam logic [LAT_W-1:0]  LAT_ONE      = LAT_W'(1);
  localparam logic [4:0]        BIT_LAST     = 5'd23;
  localparam logic [4:0]        BIT_PREFETCH = 5'd20;
  localparam logic [4:0]        BIT_CAPTURE  = 5'd22;

  typedef enum logic [2:0] {IDLE, FETCH, PRIME, SEND, STOP, LATCH} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pix_idx;
  logic [4:0]        bit_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic [23:0]       pix_hold;

  logic              busy;
  logic              done;
  logic              pix_rd;
  logic [ADDR_W-1:0] pix_addr;
  logic [23:0]       buf_data;
  logic              buf_load;
  logic              buf_shift;
  logic              buf_valid;

  // Outputs are registered: each branch sets the values seen during the next cycle.
  always_ff @(posedge scl) begin
    if (reset) begin
      state     <= IDLE;
      pix_idx   <= '0;
      bit_cnt   <= '0;
      lat_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pix_rd    <= 1'b0;
      pix_addr  <= '0;
      buf_data  <= '0;
      buf_load  <= 1'b0;
      buf_shift <= 1'b0;
      buf_valid <= 1'b0;
    end else begin
      pix_rd    <= 1'b0;
      buf_load  <= 1'b0;
      buf_shift <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= FETCH;
            busy     <= 1'b1;
            pix_idx  <= '0;
            pix_rd   <= 1'b1;
            pix_addr <= '0;
          end
        end
        FETCH: state <= PRIME;
        PRIME: begin
          // The first word goes straight from RAM to the buffer; pix_hold serves the prefetches.
          state     <= SEND;
          bit_cnt   <= '0;
          buf_load  <= 1'b1;
          buf_valid <= 1'b1;
          buf_data  <= bus.pix_data;
        end
        SEND: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt  <= '0;
            buf_load <= 1'b1;
            if (pix_idx == LAST_PIX) begin
              // tx_en only changes on a load, so an invalid load is what ends the pixel stream.
              state     <= STOP;
              buf_valid <= 1'b0;
              buf_data  <= '0;
            end else begin
              pix_idx   <= pix_idx + IDX_ONE;
              buf_valid <= 1'b1;
              buf_data  <= pix_hold;
            end
          end else begin
            bit_cnt   <= bit_cnt + 5'd1;
            buf_shift <= 1'b1;
            if (bit_cnt == BIT_PREFETCH && pix_idx != LAST_PIX) begin
              pix_rd   <= 1'b1;
              pix_addr <= pix_idx + IDX_ONE;
            end
          end
        end
        STOP: begin
          state   <= LATCH;
          lat_cnt <= '0;
          done    <= (LAT_LAST == '0);
        end
        LATCH: begin
          if (lat_cnt == LAT_LAST) begin
`ifdef WS2812B_AUTO_REFRESH_EN
            state    <= FETCH;
            pix_idx  <= '0;
            pix_rd   <= 1'b1;
            pix_addr <= '0;
`else
            state    <= IDLE;
            busy     <= 1'b0;
`endif
          end else begin
            lat_cnt <= lat_cnt + LAT_ONE;
            done    <= ((lat_cnt + LAT_ONE) == LAT_LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Prefetched word arrives the cycle after the bit-21 read strobe.
  always_ff @(posedge scl) begin
    if (state == SEND && bit_cnt == BIT_CAPTURE) pix_hold <= bus.pix_data;
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pix_rd    = pix_rd;
  assign bus.pix_addr  = pix_addr;
  assign bus.buf_data  = buf_data;
  assign bus.buf_load  = buf_load;
  assign bus.buf_shift = buf_shift;
  assign bus.buf_valid = buf_valid;

endmodule

// File: tb/tb_ws2812b_frame_sequencer.sv
// Bench for ws2812b_frame_sequencer: a 3-LED and a 1-LED instance checked against a
// frame-timeline model (expected outputs derived from the cycle index within a frame).
module tb_ws2812b_frame_sequencer;

`ifdef WS2812B_AUTO_REFRESH_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int LAT = 4;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        rd;
    logic        load;
    logic        shift;
    logic        valid;
    logic [7:0]  addr;
    logic [23:0] data;
  } out_t;

  localparam out_t M_STB  = '{busy:1'b1, done:1'b1, rd:1'b1, load:1'b1, shift:1'b1, valid:1'b0, addr:8'h00, data:24'h0};
  localparam out_t M_TBL  = '{busy:1'b1, done:1'b1, rd:1'b1, load:1'b1, shift:1'b0, valid:1'b0, addr:8'h00, data:24'h0};
  localparam out_t M_ADDR = '{busy:1'b0, done:1'b0, rd:1'b0, load:1'b0, shift:1'b0, valid:1'b0, addr:8'hFF, data:24'h0};
  localparam out_t M_LDV  = '{busy:1'b0, done:1'b0, rd:1'b0, load:1'b0, shift:1'b0, valid:1'b1, addr:8'h00, data:24'hFFFFFF};
  localparam out_t M_ALL  = '{busy:1'b1, done:1'b1, rd:1'b1, load:1'b1, shift:1'b1, valid:1'b1, addr:8'hFF, data:24'hFFFFFF};

  typedef struct {
    int          dut;
    int          cyc;
    bit          rd;
    logic [7:0]  addr;
    bit          load;
    bit          valid;
    logic [23:0] data;
    bit          done;
    bit          busy;
  } vec_t;

  logic        scl;
  logic        reset;
  logic        start;
  logic [23:0] mem [0:255];
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          chk_en   = 1'b0;

  int NL [2] = '{3, 1};
  bit act [2];
  int kk  [2];
  bit rst_seen;

  ws2812b_frame_sequencer_if #(.ADDR_W(8)) if3 ();
  ws2812b_frame_sequencer_if #(.ADDR_W(8)) if1 ();

  assign if3.start = start;
  assign if1.start = start;

  ws2812b_frame_sequencer #(.NUM_LEDS(3), .ADDR_W(8), .LATCH_CYCLES(LAT)) u3 (
    .scl(scl), .reset(reset), .bus(if3)
  );
  ws2812b_frame_sequencer #(.NUM_LEDS(1), .ADDR_W(8), .LATCH_CYCLES(LAT)) u1 (
    .scl(scl), .reset(reset), .bus(if1)
  );

  initial scl = 1'b0;
  always #5 scl = ~scl;

  // Synchronous pixel RAM, one per instance.
  always @(posedge scl) if (if3.pix_rd) if3.pix_data <= mem[if3.pix_addr];
  always @(posedge scl) if (if1.pix_rd) if1.pix_data <= mem[if1.pix_addr];

  // Frame timeline: k = cycles since the FETCH cycle of the current frame.
  always @(posedge scl) begin
    rst_seen <= reset;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        act[d] <= 1'b0;
        kk[d]  <= 0;
      end else if (!act[d]) begin
        if (start) begin
          act[d] <= 1'b1;
          kk[d]  <= 0;
        end
      end else if (kk[d] == 2 + 24 * NL[d] + LAT) begin
        if (AUTO) kk[d] <= 0;
        else act[d] <= 1'b0;
      end else begin
        kk[d] <= kk[d] + 1;
      end
    end
  end

  function automatic out_t model_out(int n, bit a, int k);
    out_t e = '0;
    if (!a) return e;
    e.busy = 1'b1;
    if (k == 0) begin e.rd = 1'b1; e.addr = 8'h00; end
    for (int p = 0; p < n - 1; p++)
      if (k == 2 + 24 * p + 21) begin e.rd = 1'b1; e.addr = 8'(p + 1); end
    for (int p = 0; p < n; p++)
      if (k == 2 + 24 * p) begin e.load = 1'b1; e.valid = 1'b1; e.data = mem[p]; end
    if (k > 2 && k < 2 + 24 * n && ((k - 2) % 24) != 0) e.shift = 1'b1;
    if (k == 2 + 24 * n) begin e.load = 1'b1; e.valid = 1'b0; e.data = 24'h0; end
    if (k == 2 + 24 * n + LAT) e.done = 1'b1;
    return e;
  endfunction

  function automatic out_t observe(int d);
    out_t o;
    if (d == 0) begin
      o.busy = if3.busy; o.done = if3.done; o.rd = if3.pix_rd; o.load = if3.buf_load;
      o.shift = if3.buf_shift; o.valid = if3.buf_valid; o.addr = if3.pix_addr; o.data = if3.buf_data;
    end else begin
      o.busy = if1.busy; o.done = if1.done; o.rd = if1.pix_rd; o.load = if1.buf_load;
      o.shift = if1.buf_shift; o.valid = if1.buf_valid; o.addr = if1.pix_addr; o.data = if1.buf_data;
    end
    return o;
  endfunction

  task automatic cmp(input string name, input out_t got, input out_t want, input out_t mask);
    n_checks++;
    if ((got & mask) === (want & mask)) n_pass++;
    else $display("FAIL %s: got %h required %h (t=%0t)", name, got & mask, want & mask, $time);
  endtask

  task automatic cmp_int(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, got, want);
  endtask

  // Continuous check of every output against the timeline model.
  always @(negedge scl) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        out_t o, e;
        o = observe(d);
        e = model_out(NL[d], act[d], kk[d]);
        if (rst_seen) cmp($sformatf("reset_vals_n%0d", NL[d]), o, '0, M_ALL);
        else          cmp($sformatf("strobes_n%0d_k%0d", NL[d], kk[d]), o, e, M_STB);
        if (e.rd)   cmp($sformatf("addr_n%0d_k%0d", NL[d], kk[d]), o, e, M_ADDR);
        if (e.load) cmp($sformatf("load_n%0d_k%0d", NL[d], kk[d]), o, e, M_LDV);
      end
    end
  end

  vec_t tbl [$];

  task automatic set_test_mem();
    for (int i = 0; i < 256; i++) mem[i] = 24'h0;
    mem[0] = 24'hFF0000;
    mem[1] = 24'h00FF00;
    mem[2] = 24'h0000FF;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge scl);
    reset = 1'b0;
    @(negedge scl);
  endtask

  task automatic run_table();
    int shifts;
    shifts = 0;
    @(negedge scl); start = 1'b1;
    @(negedge scl); start = 1'b0;
    for (int c = 0; c <= 82; c++) begin
      if (c > 2 && c < 74 && if3.buf_shift === 1'b1) shifts++;
      foreach (tbl[i]) begin
        if (tbl[i].cyc == c) begin
          out_t o, w;
          o = observe(tbl[i].dut);
          w = '0;
          w.busy = tbl[i].busy; w.done = tbl[i].done; w.rd = tbl[i].rd; w.load = tbl[i].load;
          w.addr = tbl[i].addr; w.valid = tbl[i].valid; w.data = tbl[i].data;
          cmp($sformatf("tbl_n%0d_c%0d", NL[tbl[i].dut], c), o, w, M_TBL);
          if (tbl[i].rd)   cmp($sformatf("tbl_addr_n%0d_c%0d", NL[tbl[i].dut], c), o, w, M_ADDR);
          if (tbl[i].load) cmp($sformatf("tbl_load_n%0d_c%0d", NL[tbl[i].dut], c), o, w, M_LDV);
        end
      end
      @(negedge scl);
    end
    cmp_int("shift_count_n3", shifts, 69);
  endtask

  initial begin
    start = 1'b0;
    reset = 1'b1;
    set_test_mem();

    //          dut cyc rd addr   load vld data         done busy
    tbl.push_back('{0,  0, 1, 8'd0, 0, 0, 24'h000000, 0, 1});
    tbl.push_back('{0,  1, 0, 8'd0, 0, 0, 24'h000000, 0, 1});
    tbl.push_back('{0,  2, 0, 8'd0, 1, 1, 24'hFF0000, 0, 1});
    tbl.push_back('{0, 23, 1, 8'd1, 0, 0, 24'h000000, 0, 1});
    tbl.push_back('{0, 26, 0, 8'd0, 1, 1, 24'h00FF00, 0, 1});
    tbl.push_back('{0, 47, 1, 8'd2, 0, 0, 24'h000000, 0, 1});
    tbl.push_back('{0, 50, 0, 8'd0, 1, 1, 24'h0000FF, 0, 1});
    tbl.push_back('{0, 71, 0, 8'd0, 0, 0, 24'h000000, 0, 1});
    tbl.push_back('{0, 74, 0, 8'd0, 1, 0, 24'h000000, 0, 1});
    tbl.push_back('{0, 77, 0, 8'd0, 0, 0, 24'h000000, 0, 1});
    tbl.push_back('{0, 78, 0, 8'd0, 0, 0, 24'h000000, 1, 1});
    tbl.push_back('{0, 79, AUTO, 8'd0, 0, 0, 24'h000000, 0, AUTO});
    tbl.push_back('{1,  0, 1, 8'd0, 0, 0, 24'h000000, 0, 1});
    tbl.push_back('{1,  2, 0, 8'd0, 1, 1, 24'hFF0000, 0, 1});
    tbl.push_back('{1, 23, 0, 8'd0, 0, 0, 24'h000000, 0, 1});
    tbl.push_back('{1, 26, 0, 8'd0, 1, 0, 24'h000000, 0, 1});
    tbl.push_back('{1, 30, 0, 8'd0, 0, 0, 24'h000000, 1, 1});
    tbl.push_back('{1, 31, AUTO, 8'd0, 0, 0, 24'h000000, 0, AUTO});

    @(negedge scl);
    chk_en = 1'b1;
    @(negedge scl);
    reset = 1'b0;
    cmp("por_n3", observe(0), '0, M_ALL);
    cmp("por_n1", observe(1), '0, M_ALL);

    run_table();

    // Reset in the middle of the second pixel, then an identical fresh frame.
    do_reset();
    @(negedge scl); start = 1'b1;
    @(negedge scl); start = 1'b0;
    repeat (30) @(negedge scl);
    reset = 1'b1;
    @(negedge scl);
    reset = 1'b0;
    cmp("midreset_n3", observe(0), '0, M_ALL);
    cmp("midreset_n1", observe(1), '0, M_ALL);
    repeat (3) @(negedge scl);
    run_table();

`ifndef WS2812B_AUTO_REFRESH_EN
    // start held high for the whole frame: one frame only, no queued restart.
    begin
      int loads, dones;
      bit found;
      do_reset();
      loads = 0; found = 1'b0;
      start = 1'b1;
      for (int c = 0; c < 100 && !found; c++) begin
        @(negedge scl);
        if (if3.buf_load === 1'b1 && if3.buf_valid === 1'b1) loads++;
        if (if3.done === 1'b1) found = 1'b1;
      end
      start = 1'b0;
      cmp_int("held_start_done_seen", int'(found), 1);
      cmp_int("held_start_loads", loads, 3);
      dones = 0;
      repeat (40) begin
        @(negedge scl);
        if (if3.done === 1'b1 || if3.busy === 1'b1) dones++;
      end
      cmp_int("held_start_no_rerun", dones, 0);
      start = 1'b1;
      @(negedge scl);
      start = 1'b0;
      loads = 0; dones = 0;
      repeat (100) begin
        @(negedge scl);
        if (if3.buf_load === 1'b1 && if3.buf_valid === 1'b1) loads++;
        if (if3.done === 1'b1) dones++;
      end
      cmp_int("repulse_loads", loads, 3);
      cmp_int("repulse_done", dones, 1);
    end
`endif

    // Random frame requests and resets with random pixel contents.
    for (int it = 0; it < 30; it++) begin
      int len;
      do_reset();
      for (int i = 0; i < 3; i++) mem[i] = 24'($urandom);
      len = int'($urandom_range(80, 250));
      for (int c = 0; c < len; c++) begin
        start = ($urandom_range(0, 7) == 0);
        reset = ($urandom_range(0, 199) == 0);
        @(negedge scl);
      end
      start = 1'b0;
      reset = 1'b0;
    end

    repeat (3) @(negedge scl);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
